judgment_overlay_gen: RTL and testbench
=======================================

JUDGMENT_OVERLAY_GEN -- requirements
Module: judgment_overlay_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 1280, the active pixels per line.
REQ-002 The block SHALL have parameter V_ACTIVE, default 720, the active lines per frame.
REQ-003 The block SHALL have parameter CROSS_HALF, default 8, the crosshair arm half-length in pixels.
REQ-004 The block SHALL have parameter JUDGE_RADIUS, default 16, the judgment square-ring radius in pixels.
REQ-005 The block SHALL have parameter FLASH_FRAMES, default 30, the judgment display duration in frames (range 1..255).
REQ-006 The block SHALL have port clk_in, input, 1 bit: the pixel clock; it is the only clock.
REQ-007 The block SHALL have port rst_n_in, input, 1 bit: the reset, asynchronous and active-low.
REQ-008 The block SHALL have ports hcount_in (input, 11 bits) and vcount_in (input, 10 bits): the current pixel position.
REQ-009 The block SHALL have port frame_start_in, input, 1 bit: a one-cycle pulse at the start of each frame.
REQ-010 The block SHALL have ports target_valid_in (input, 1 bit), target_x_in (input, 11 bits) and target_y_in (input, 10 bits): a target-position update strobe with its coordinates.
REQ-011 The block SHALL have port target_clear_in, input, 1 bit: a pulse that removes the target.
REQ-012 The block SHALL have ports judge_valid_in (input, 1 bit), judge_correct_in (input, 1 bit), judge_x_in (input, 11 bits) and judge_y_in (input, 10 bits): a judgment event request with its result and position.
REQ-013 The block SHALL have port judge_ready_out, output, 1 bit: the judgment handshake ready.
REQ-014 The block SHALL have ports crosshair_out, judgment_out and judgment_correct_out, each an output of 1 bit: the per-pixel overlay selects consumed by the video compositor.

Function
REQ-015 The target position SHALL be double-buffered: target_valid_in loads the pending x/y and sets pending_valid; target_clear_in clears pending_valid; if both are asserted in the same cycle, clear wins.
REQ-016 On frame_start_in the active target SHALL copy the pending target; a target update or clear in that same cycle SHALL be bypassed into the active copy, so the new value is used.
REQ-017 A judgment transfer SHALL occur when judge_valid_in && judge_ready_out on a rising clk_in edge; it captures the x, y and correct inputs.
REQ-018 The FSM SHALL have three states: IDLE, ARMED and SHOW; judge_ready_out SHALL be 1 only in IDLE.
REQ-019 In IDLE, a transfer SHALL move the FSM to ARMED, even if frame_start_in is high in the same cycle; that pulse does not advance the FSM.
REQ-020 In ARMED, frame_start_in SHALL move the FSM to SHOW and load frame_cnt = FLASH_FRAMES-1.
REQ-021 In SHOW, frame_start_in with frame_cnt > 0 SHALL decrement frame_cnt; frame_start_in with frame_cnt == 0 SHALL move the FSM to IDLE, so the judgment is displayed for exactly FLASH_FRAMES whole frames.
REQ-022 Requests arriving while the FSM is not in IDLE SHALL stall; they are never dropped or queued.
REQ-023 Distances SHALL be computed as signed 12-bit values: dx = hcount − x and dy = vcount − y, using absolute values; the computation SHALL not wrap at the screen edges.
REQ-024 The pixel SHALL be in the active area when hcount_in < H_ACTIVE && vcount_in < V_ACTIVE; every overlay output SHALL be 0 outside the active area.
REQ-025 crosshair_out SHALL be 1 when the active target is valid and either (dx == 0 && |dy| <= CROSS_HALF) or (dy == 0 && |dx| <= CROSS_HALF).
REQ-026 judgment_out SHALL be 1 in SHOW when max(|dx|, |dy|) == JUDGE_RADIUS, measured relative to the judgment position.
REQ-027 judgment_correct_out SHALL equal the captured correct bit when judgment_out is 1, and SHALL be 0 otherwise.
REQ-028 All overlay outputs SHALL be registered, with exactly 1 cycle of latency from hcount_in/vcount_in; shapes that cross the screen edge SHALL be clipped by REQ-024.

Reset
REQ-029 Asserting rst_n_in low SHALL immediately force: FSM = IDLE, frame_cnt = 0, pending_valid = 0, active-target valid = 0, and all overlay outputs = 0.
REQ-030 While rst_n_in is low, judge_ready_out SHALL be 0; after rst_n_in deasserts it SHALL become 1 from the first clock edge.
REQ-031 A reset during ARMED or SHOW SHALL discard the judgment, and no overlay pixel SHALL be output afterwards.

Configuration
REQ-032 When macro JUDGE_BLINK_EN is defined, judgment_out in SHOW SHALL be additionally gated by frame_cnt[2] == 0, giving 4 frames on and 4 frames off.
REQ-033 When JUDGE_BLINK_EN is undefined, judgment_out SHALL stay steady for all FLASH_FRAMES frames, and no blink logic SHALL be present.

Verification
REQ-034 The bench SHALL cover: target (640,360) loaded mid-frame -> no crosshair that frame; the next frame -> crosshair_out=1 at (640,352..368) and at (632..648,360), and 0 at (640,369), 1 cycle after each count.
REQ-035 The bench SHALL cover: target_valid_in and frame_start_in in the same cycle with (100,100) -> the crosshair appears at (100,100) in the frame that is starting.
REQ-036 The bench SHALL cover: judge request correct=1 at (200,300) -> judge_ready_out=0 the next cycle; the ring appears at the next frame_start; judgment_correct_out=1 at (216,300) and (184,284); it appears for 30 frames, then ready=1.
REQ-037 The bench SHALL cover: a second request held during SHOW -> it stalls and is accepted in the cycle after the return to IDLE; its correct=0 -> judgment_correct_out=0 at the ring pixels.
REQ-038 The bench SHALL cover: target (5,5) -> the crosshair is clipped at x=0/y=0 with no wrap artifacts at x=2043; hcount_in=1280 -> all outputs 0.
REQ-039 The bench SHALL cover: rst_n_in pulsed low mid-SHOW -> outputs 0 asynchronously and FSM IDLE; with JUDGE_BLINK_EN, a 30-frame show -> ring visible on frames where frame_cnt[2]=0 only.

Source files
------------

// File: rtl/judgment_overlay_gen.sv
// Crosshair and judgment-ring overlay generator with a frame-timed judgment FSM.
// Optional macro JUDGE_BLINK_EN blinks the judgment ring 4 frames on / 4 frames off.
module judgment_overlay_gen #(
   parameter int H_ACTIVE     = 1280,
   parameter int V_ACTIVE     = 720,
   parameter int CROSS_HALF   = 8,
   parameter int JUDGE_RADIUS = 16,
   parameter int FLASH_FRAMES = 30
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic        frame_start_in,
   input  logic        target_valid_in,
   input  logic [10:0] target_x_in,
   input  logic [9:0]  target_y_in,
   input  logic        target_clear_in,
   input  logic        judge_valid_in,
   input  logic        judge_correct_in,
   input  logic [10:0] judge_x_in,
   input  logic [9:0]  judge_y_in,
   output logic        judge_ready_out,
   output logic        crosshair_out,
   output logic        judgment_out,
   output logic        judgment_correct_out
);

   // state | meaning
   // IDLE  | no judgment pending, accepting requests
   // ARMED | judgment captured, waiting for the next frame start
   // SHOW  | ring displayed; frame_cnt counts remaining frames down to 0
   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SHOW} state_t;

   localparam logic [10:0] H_LIM      = 11'(H_ACTIVE);
   localparam logic [9:0]  V_LIM      = 10'(V_ACTIVE);
   localparam logic [11:0] CROSS_LIM  = 12'(CROSS_HALF);
   localparam logic [11:0] RING_RAD   = 12'(JUDGE_RADIUS);
   localparam logic [7:0]  FLASH_LAST = 8'(FLASH_FRAMES - 1);

   state_t      state_q, state_d;
   logic [7:0]  frame_cnt_q, frame_cnt_d;
   logic        rdy_q;
   logic [10:0] pend_x_q, pend_x_d;
   logic [9:0]  pend_y_q, pend_y_d;
   logic        pend_v_q, pend_v_d;
   logic [10:0] act_x_q, act_x_d;
   logic [9:0]  act_y_q, act_y_d;
   logic        act_v_q, act_v_d;
   logic [10:0] jud_x_q, jud_x_d;
   logic [9:0]  jud_y_q, jud_y_d;
   logic        jud_c_q, jud_c_d;
   logic        cross_q, cross_d;
   logic        ring_q, ring_d;
   logic        ring_c_q, ring_c_d;
   logic        xfer;

   // rdy_q keeps ready low throughout reset and raises it on the first edge after.
   assign judge_ready_out = rdy_q && (state_q == S_IDLE);
   assign xfer            = judge_valid_in && judge_ready_out;

   always_comb begin
      pend_x_d = pend_x_q;
      pend_y_d = pend_y_q;
      pend_v_d = pend_v_q;
      act_x_d  = act_x_q;
      act_y_d  = act_y_q;
      act_v_d  = act_v_q;
      if (target_valid_in) begin
         pend_x_d = target_x_in;
         pend_y_d = target_y_in;
         pend_v_d = 1'b1;
      end
      if (target_clear_in) pend_v_d = 1'b0;
      // Same-cycle updates bypass straight into the active copy at frame start.
      if (frame_start_in) begin
         act_x_d = pend_x_d;
         act_y_d = pend_y_d;
         act_v_d = pend_v_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      jud_x_d     = jud_x_q;
      jud_y_d     = jud_y_q;
      jud_c_d     = jud_c_q;
      case (state_q)
         S_IDLE: begin
            if (xfer) begin
               jud_x_d = judge_x_in;
               jud_y_d = judge_y_in;
               jud_c_d = judge_correct_in;
               state_d = S_ARMED;
            end
         end
         S_ARMED: begin
            if (frame_start_in) begin
               state_d     = S_SHOW;
               frame_cnt_d = FLASH_LAST;
            end
         end
         S_SHOW: begin
            if (frame_start_in) begin
               if (frame_cnt_q != 8'd0) frame_cnt_d = frame_cnt_q - 8'd1;
               else                     state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   function automatic logic [11:0] abs12(input logic signed [11:0] v);
      return v[11] ? 12'(-v) : 12'(v);
   endfunction

   logic signed [11:0] dx_t, dy_t, dx_j, dy_j;
   logic [11:0]        adx_t, ady_t, adx_j, ady_j, max_j;
   logic               in_active, ring_hit;

   // 12-bit signed differences cover the full 11-bit range, so nothing wraps.
   assign dx_t  = $signed({1'b0, hcount_in}) - $signed({1'b0, act_x_q});
   assign dy_t  = $signed({2'b0, vcount_in}) - $signed({2'b0, act_y_q});
   assign dx_j  = $signed({1'b0, hcount_in}) - $signed({1'b0, jud_x_q});
   assign dy_j  = $signed({2'b0, vcount_in}) - $signed({2'b0, jud_y_q});
   assign adx_t = abs12(dx_t);
   assign ady_t = abs12(dy_t);
   assign adx_j = abs12(dx_j);
   assign ady_j = abs12(dy_j);
   assign max_j = (adx_j >= ady_j) ? adx_j : ady_j;

   assign in_active = (hcount_in < H_LIM) && (vcount_in < V_LIM);

`ifdef JUDGE_BLINK_EN
   assign ring_hit = (state_q == S_SHOW) && (max_j == RING_RAD) && !frame_cnt_q[2];
`else
   assign ring_hit = (state_q == S_SHOW) && (max_j == RING_RAD);
`endif

   always_comb begin
      cross_d  = in_active && act_v_q &&
                 (((dx_t == 12'sd0) && (ady_t <= CROSS_LIM)) ||
                  ((dy_t == 12'sd0) && (adx_t <= CROSS_LIM)));
      ring_d   = in_active && ring_hit;
      ring_c_d = in_active && ring_hit && jud_c_q;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= S_IDLE;
         frame_cnt_q <= 8'd0;
         rdy_q       <= 1'b0;
         pend_x_q    <= 11'd0;
         pend_y_q    <= 10'd0;
         pend_v_q    <= 1'b0;
         act_x_q     <= 11'd0;
         act_y_q     <= 10'd0;
         act_v_q     <= 1'b0;
         jud_x_q     <= 11'd0;
         jud_y_q     <= 10'd0;
         jud_c_q     <= 1'b0;
         cross_q     <= 1'b0;
         ring_q      <= 1'b0;
         ring_c_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         rdy_q       <= 1'b1;
         pend_x_q    <= pend_x_d;
         pend_y_q    <= pend_y_d;
         pend_v_q    <= pend_v_d;
         act_x_q     <= act_x_d;
         act_y_q     <= act_y_d;
         act_v_q     <= act_v_d;
         jud_x_q     <= jud_x_d;
         jud_y_q     <= jud_y_d;
         jud_c_q     <= jud_c_d;
         cross_q     <= cross_d;
         ring_q      <= ring_d;
         ring_c_q    <= ring_c_d;
      end
   end

   assign crosshair_out        = cross_q;
   assign judgment_out         = ring_q;
   assign judgment_correct_out = ring_c_q;

endmodule

// File: tb/tb_judgment_overlay_gen.sv
// Directed bench for judgment_overlay_gen; counts are driven directly rather than
// scanned, so each frame costs only a few clocks.
module tb_judgment_overlay_gen;
   logic        clk_in = 1'b0;
   logic        rst_n_in = 1'b0;
   logic [10:0] hcount_in = '0;
   logic [9:0]  vcount_in = '0;
   logic        frame_start_in = 1'b0;
   logic        target_valid_in = 1'b0;
   logic [10:0] target_x_in = '0;
   logic [9:0]  target_y_in = '0;
   logic        target_clear_in = 1'b0;
   logic        judge_valid_in = 1'b0;
   logic        judge_correct_in = 1'b0;
   logic [10:0] judge_x_in = '0;
   logic [9:0]  judge_y_in = '0;
   logic        judge_ready_out, crosshair_out, judgment_out, judgment_correct_out;

   int vec = 0;
   int errs = 0;

   judgment_overlay_gen dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in),
      .hcount_in(hcount_in), .vcount_in(vcount_in),
      .frame_start_in(frame_start_in),
      .target_valid_in(target_valid_in), .target_x_in(target_x_in),
      .target_y_in(target_y_in), .target_clear_in(target_clear_in),
      .judge_valid_in(judge_valid_in), .judge_correct_in(judge_correct_in),
      .judge_x_in(judge_x_in), .judge_y_in(judge_y_in),
      .judge_ready_out(judge_ready_out), .crosshair_out(crosshair_out),
      .judgment_out(judgment_out), .judgment_correct_out(judgment_correct_out)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic pix(input int h, input int v);
      hcount_in = 11'(h);
      vcount_in = 10'(v);
      tick();
   endtask

   task automatic frame_pulse();
      frame_start_in = 1'b1;
      tick();
      frame_start_in = 1'b0;
   endtask

   // Ring visibility for a given frame_cnt value.
   function automatic logic exp_vis(input int cnt);
`ifdef JUDGE_BLINK_EN
      return ((cnt >> 2) & 1) == 0;
`else
      return 1'b1;
`endif
   endfunction

   task automatic test_reset();
      #2;
      vec++;
      if (judge_ready_out !== 1'b0 || crosshair_out !== 1'b0 || judgment_out !== 1'b0
          || judgment_correct_out !== 1'b0) begin
         errs++;
         $display("FAIL reset_outputs: rdy=%b ch=%b j=%b jc=%b, want all 0",
                  judge_ready_out, crosshair_out, judgment_out, judgment_correct_out);
      end
      tick(); tick();
      vec++;
      if (judge_ready_out !== 1'b0) begin
         errs++; $display("FAIL reset_ready_held: got %b want 0", judge_ready_out);
      end
      #2 rst_n_in = 1'b1;
      tick();
      vec++;
      if (judge_ready_out !== 1'b1) begin
         errs++; $display("FAIL ready_after_reset: got %b want 1", judge_ready_out);
      end
   endtask

   task automatic test_crosshair();
      target_valid_in = 1'b1; target_x_in = 11'd640; target_y_in = 10'd360;
      tick();
      target_valid_in = 1'b0;
      pix(640, 360);
      vec++;
      if (crosshair_out !== 1'b0) begin
         errs++; $display("FAIL cross_same_frame: got %b want 0", crosshair_out);
      end
      frame_pulse();
      for (int d = -8; d <= 8; d++) begin
         pix(640, 360 + d);
         vec++;
         if (crosshair_out !== 1'b1) begin
            errs++; $display("FAIL cross_vert dy=%0d: got %b want 1", d, crosshair_out);
         end
         pix(640 + d, 360);
         vec++;
         if (crosshair_out !== 1'b1) begin
            errs++; $display("FAIL cross_horz dx=%0d: got %b want 1", d, crosshair_out);
         end
      end
      pix(640, 369);
      vec++;
      if (crosshair_out !== 1'b0) begin
         errs++; $display("FAIL cross_end_369: got %b want 0", crosshair_out);
      end
      pix(631, 360);
      vec++;
      if (crosshair_out !== 1'b0) begin
         errs++; $display("FAIL cross_end_631: got %b want 0", crosshair_out);
      end
      pix(641, 361);
      vec++;
      if (crosshair_out !== 1'b0) begin
         errs++; $display("FAIL cross_diag: got %b want 0", crosshair_out);
      end
   endtask

   task automatic test_same_cycle();
      target_valid_in = 1'b1; target_x_in = 11'd100; target_y_in = 10'd100;
      frame_start_in = 1'b1;
      tick();
      target_valid_in = 1'b0; frame_start_in = 1'b0;
      pix(100, 100);
      vec++;
      if (crosshair_out !== 1'b1) begin
         errs++; $display("FAIL bypass_load: got %b want 1", crosshair_out);
      end
      pix(640, 360);
      vec++;
      if (crosshair_out !== 1'b0) begin
         errs++; $display("FAIL old_target_gone: got %b want 0", crosshair_out);
      end
   endtask

   task automatic test_clear();
      target_valid_in = 1'b1; target_clear_in = 1'b1;
      target_x_in = 11'd300; target_y_in = 10'd300;
      tick();
      target_valid_in = 1'b0; target_clear_in = 1'b0;
      frame_pulse();
      pix(300, 300);
      vec++;
      if (crosshair_out !== 1'b0) begin
         errs++; $display("FAIL clear_wins: got %b want 0", crosshair_out);
      end
      target_valid_in = 1'b1;
      tick();
      target_valid_in = 1'b0;
      target_clear_in = 1'b1; frame_start_in = 1'b1;
      tick();
      target_clear_in = 1'b0; frame_start_in = 1'b0;
      pix(300, 300);
      vec++;
      if (crosshair_out !== 1'b0) begin
         errs++; $display("FAIL clear_bypass: got %b want 0", crosshair_out);
      end
   endtask

   task automatic test_judge();
      logic e;
      judge_valid_in = 1'b1; judge_correct_in = 1'b1;
      judge_x_in = 11'd200; judge_y_in = 10'd300;
      tick();
      judge_valid_in = 1'b0;
      vec++;
      if (judge_ready_out !== 1'b0) begin
         errs++; $display("FAIL judge_ready_drop: got %b want 0", judge_ready_out);
      end
      pix(216, 300);
      vec++;
      if (judgment_out !== 1'b0) begin
         errs++; $display("FAIL ring_before_frame: got %b want 0", judgment_out);
      end
      for (int f = 0; f < 30; f++) begin
         frame_pulse();
         e = exp_vis(29 - f);
         pix(216, 300);
         vec++;
         if (judgment_out !== e || judgment_correct_out !== e) begin
            errs++;
            $display("FAIL ring_frame%0d: j=%b jc=%b want %b", f, judgment_out,
                     judgment_correct_out, e);
         end
         if (f == 4) begin
            pix(184, 284);
            vec++;
            if (judgment_out !== e || judgment_correct_out !== e) begin
               errs++;
               $display("FAIL ring_corner: j=%b jc=%b want %b", judgment_out,
                        judgment_correct_out, e);
            end
            pix(200, 300);
            vec++;
            if (judgment_out !== 1'b0) begin
               errs++; $display("FAIL ring_center: got %b want 0", judgment_out);
            end
            pix(217, 300);
            vec++;
            if (judgment_out !== 1'b0) begin
               errs++; $display("FAIL ring_outside: got %b want 0", judgment_out);
            end
         end
      end
      frame_pulse();
      vec++;
      if (judge_ready_out !== 1'b1) begin
         errs++; $display("FAIL ready_after_show: got %b want 1", judge_ready_out);
      end
      pix(216, 300);
      vec++;
      if (judgment_out !== 1'b0) begin
         errs++; $display("FAIL ring_after_show: got %b want 0", judgment_out);
      end
   endtask

   task automatic test_back_to_back();
      judge_valid_in = 1'b1; judge_correct_in = 1'b1;
      judge_x_in = 11'd200; judge_y_in = 10'd300;
      tick();
      judge_correct_in = 1'b0; judge_x_in = 11'd400; judge_y_in = 10'd200;
      frame_pulse();
      for (int k = 1; k <= 29; k++) begin
         frame_pulse();
         vec++;
         if (judge_ready_out !== 1'b0) begin
            errs++; $display("FAIL stall_k%0d: ready=%b want 0", k, judge_ready_out);
         end
      end
      pix(216, 300);
      vec++;
      if (judgment_correct_out !== exp_vis(0)) begin
         errs++; $display("FAIL first_kept: jc=%b want %b", judgment_correct_out, exp_vis(0));
      end
      frame_pulse();
      vec++;
      if (judge_ready_out !== 1'b1) begin
         errs++; $display("FAIL stall_release: ready=%b want 1", judge_ready_out);
      end
      tick();
      judge_valid_in = 1'b0;
      vec++;
      if (judge_ready_out !== 1'b0) begin
         errs++; $display("FAIL second_accept: ready=%b want 0", judge_ready_out);
      end
      frame_pulse(); frame_pulse(); frame_pulse();
      pix(416, 200);
      vec++;
      if (judgment_out !== exp_vis(27) || judgment_correct_out !== 1'b0) begin
         errs++;
         $display("FAIL second_ring: j=%b jc=%b want %b/0", judgment_out,
                  judgment_correct_out, exp_vis(27));
      end
      pix(384, 184);
      vec++;
      if (judgment_out !== exp_vis(27) || judgment_correct_out !== 1'b0) begin
         errs++;
         $display("FAIL second_corner: j=%b jc=%b want %b/0", judgment_out,
                  judgment_correct_out, exp_vis(27));
      end
      for (int k = 0; k < 28; k++) frame_pulse();
      vec++;
      if (judge_ready_out !== 1'b1) begin
         errs++; $display("FAIL second_done: ready=%b want 1", judge_ready_out);
      end
   endtask

   task automatic test_edge();
      target_valid_in = 1'b1; target_x_in = 11'd5; target_y_in = 10'd5;
      frame_start_in = 1'b1;
      tick();
      target_valid_in = 1'b0; frame_start_in = 1'b0;
      pix(0, 5);
      vec++;
      if (crosshair_out !== 1'b1) begin
         errs++; $display("FAIL clip_x0: got %b want 1", crosshair_out);
      end
      pix(5, 0);
      vec++;
      if (crosshair_out !== 1'b1) begin
         errs++; $display("FAIL clip_y0: got %b want 1", crosshair_out);
      end
      pix(2043, 5);
      vec++;
      if (crosshair_out !== 1'b0) begin
         errs++; $display("FAIL no_wrap_2043: got %b want 0", crosshair_out);
      end
      target_valid_in = 1'b1; target_x_in = 11'd1276; target_y_in = 10'd360;
      frame_start_in = 1'b1;
      tick();
      target_valid_in = 1'b0; frame_start_in = 1'b0;
      pix(1279, 360);
      vec++;
      if (crosshair_out !== 1'b1) begin
         errs++; $display("FAIL right_edge_in: got %b want 1", crosshair_out);
      end
      pix(1280, 360);
      vec++;
      if (crosshair_out !== 1'b0 || judgment_out !== 1'b0 || judgment_correct_out !== 1'b0) begin
         errs++; $display("FAIL h1280_blank: ch=%b j=%b jc=%b want 0", crosshair_out,
                          judgment_out, judgment_correct_out);
      end
      target_valid_in = 1'b1; target_x_in = 11'd640; target_y_in = 10'd716;
      frame_start_in = 1'b1;
      tick();
      target_valid_in = 1'b0; frame_start_in = 1'b0;
      pix(640, 719);
      vec++;
      if (crosshair_out !== 1'b1) begin
         errs++; $display("FAIL bottom_in: got %b want 1", crosshair_out);
      end
      pix(640, 720);
      vec++;
      if (crosshair_out !== 1'b0) begin
         errs++; $display("FAIL v720_blank: got %b want 0", crosshair_out);
      end
   endtask

   task automatic test_reset_show();
      judge_valid_in = 1'b1; judge_correct_in = 1'b1;
      judge_x_in = 11'd200; judge_y_in = 10'd300;
      tick();
      judge_valid_in = 1'b0;
      frame_pulse(); frame_pulse(); frame_pulse();
      pix(216, 300);
      vec++;
      if (judgment_out !== 1'b1) begin
         errs++; $display("FAIL pre_reset_ring: got %b want 1", judgment_out);
      end
      hcount_in = 11'd640; vcount_in = 10'd719;
      tick();
      vec++;
      if (crosshair_out !== 1'b1) begin
         errs++; $display("FAIL pre_reset_cross: got %b want 1", crosshair_out);
      end
      hcount_in = 11'd216; vcount_in = 10'd300;
      tick();
      #2 rst_n_in = 1'b0;
      #1;
      vec++;
      if (judgment_out !== 1'b0 || judgment_correct_out !== 1'b0 || crosshair_out !== 1'b0
          || judge_ready_out !== 1'b0) begin
         errs++; $display("FAIL async_reset: j=%b jc=%b ch=%b rdy=%b want 0", judgment_out,
                          judgment_correct_out, crosshair_out, judge_ready_out);
      end
      #2 rst_n_in = 1'b1;
      tick();
      vec++;
      if (judge_ready_out !== 1'b1) begin
         errs++; $display("FAIL idle_after_reset: ready=%b want 1", judge_ready_out);
      end
      frame_pulse();
      pix(216, 300);
      vec++;
      if (judgment_out !== 1'b0) begin
         errs++; $display("FAIL ring_discarded: got %b want 0", judgment_out);
      end
      pix(640, 719);
      vec++;
      if (crosshair_out !== 1'b0) begin
         errs++; $display("FAIL target_discarded: got %b want 0", crosshair_out);
      end
   endtask

   initial begin
      test_reset();
      test_crosshair();
      test_same_cycle();
      test_clear();
      test_judge();
      test_back_to_back();
      test_edge();
      test_reset_show();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
